playback_sequencer: RTL and testbench
=====================================

Name: playback_sequencer

Overview:
- Transport controller that sequences the music player datapath.
- Turns debounced play/next button pulses and the ff/rewind switches into the play enable, song select, song-restart pulse and beat tick.
- The beat tick drives the song reader / note player.
- Sits between the button debouncers and the song_reader/note_player; shares the AC97 new_frame timebase.

Parameters:
- BEAT_COUNT, 1000: new_frame pulses per beat at normal speed; must be even and >= 4.
- NUM_SONGS, 4: number of songs; range 2..4; current_song wraps NUM_SONGS-1 -> 0.

Ports:
- clk  input  1  system clock
- reset  input  1  one clock; reset is asynchronous and active-low
- play_button  input  1  debounced one-cycle pulse; toggles play/pause
- next_button  input  1  debounced one-cycle pulse; advance song
- ff_switch  input  1  level; 1 = double beat rate
- r_switch  input  1  level; 1 = reverse playback direction
- new_frame  input  1  one-cycle pulse per codec sample
- song_done  input  1  one-cycle pulse from song_reader at end of song
- play  output  1  registered; 1 while in PLAYING
- song_reset  output  1  registered one-cycle pulse; restart song_reader at start of current_song
- current_song  output  2  registered song index
- beat  output  1  registered one-cycle beat tick
- beat_dir  output  1  registered copy of r_switch, sampled every clk; 0 forward, 1 reverse

Behaviour:
- Reset (reset=0, async): state=PAUSED, play=0, song_reset=0, current_song=0, beat=0, beat_dir=0, frame counter=0, resume flag=0.
- States and transitions:
  - PAUSED: next_button -> RESTART (advance=1, resume=0). Else play_button -> PLAYING.
  - PLAYING, priority next_button > song_done > play_button:
    - next_button -> RESTART (advance=1, resume=0).
    - song_done -> RESTART (advance/resume per Optional Feature).
    - play_button -> PAUSED.
  - RESTART (exactly one cycle):
    - song_reset=1 registered; visible the cycle after RESTART is entered.
    - If advance, current_song <= (current_song==NUM_SONGS-1) ? 0 : current_song+1.
    - Frame counter cleared; play=0.
    - Next state: PLAYING if resume, else PAUSED.
    - Buttons arriving while in RESTART are ignored.
- Latency: play changes one cycle after the state change, i.e. two clk after the button pulse edge is sampled.
- Beat generation:
  - Terminal count term = ff_switch ? BEAT_COUNT/2-1 : BEAT_COUNT-1.
  - Frame counter advances only when state==PLAYING and new_frame=1.
    - If counter >= term: counter <= 0, beat <= 1.
    - Else: counter+1, beat <= 0.
  - The >= compare makes a mid-beat switch from normal to ff fire on the next new_frame.
  - beat is 0 in all other cycles. Counter holds in PAUSED and clears in RESTART.
- Frame counter width: clog2(BEAT_COUNT); no overflow is possible.
- Simultaneous events:
  - next_button with play_button: next wins and play is ignored.
  - song_done while PAUSED: ignored.
  - new_frame during RESTART: no beat.
- Reset asserted mid-operation forces all outputs to their reset values immediately (async). Operation resumes in PAUSED at song 0 on the first clk after release.

Optional Feature:
- Macro AUTO_ADVANCE_EN.
- Defined: song_done in PLAYING -> RESTART with advance=1, resume=1. Next song starts, and play returns to 1 two cycles after song_done.
- Undefined: song_done in PLAYING -> RESTART with advance=0, resume=0. Same song rewinds (song_reset pulse), current_song unchanged, play=0.

Test Plan:
- Reset: hold reset=0 for 2 clk -> play=0, current_song=0, beat=0, song_reset=0, beat_dir=0. Assert reset=0 mid-PLAYING -> outputs clear without waiting for clk.
- BEAT_COUNT=100, play_button pulse, then 300 new_frame pulses -> play=1 two clk after the pulse; exactly 3 beats, one clk after the 100th, 200th and 300th frames.
- ff_switch=1 from start -> beat every 50 frames. Raise ff_switch after frame 70 of a beat -> beat on frame 71, then every 50.
- Four next_button pulses while PAUSED -> current_song 1,2,3,0; one song_reset pulse each; play stays 0. With NUM_SONGS=3, wrap after 2.
- PLAYING, song_done pulse:
  - AUTO_ADVANCE_EN defined -> song_reset pulse, current_song+1, play=1 again within 2 clk.
  - Undefined -> song_reset pulse, same song, play=0.
- Same-cycle play_button+next_button while PLAYING -> song advances, ends PAUSED. r_switch=1 -> beat_dir=1 next clk, beat rate unchanged.

Source files
------------

// File: rtl/playback_sequencer.sv
// playback_sequencer: transport controller for the music player datapath.
// Turns debounced play/next pulses and ff/rewind switches into play enable,
// song select, a one-cycle song-restart pulse and the beat tick that paces
// the song_reader / note_player. Shares the codec new_frame timebase.
//
// Optional build macro: AUTO_ADVANCE_EN
//   defined   : song_done while playing moves on to the next song and keeps playing
//   undefined : song_done while playing rewinds the same song and pauses
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-low
//   play_button  one-cycle pulse, toggles play/pause
//   next_button  one-cycle pulse, advance to next song
//   ff_switch    level, 1 = double beat rate
//   r_switch     level, 1 = reverse playback
//   new_frame    one-cycle pulse per codec sample
//   song_done    one-cycle pulse at end of song
//   play         1 while playing (one cycle behind the state)
//   song_reset   one-cycle restart pulse for song_reader
//   current_song selected song index
//   beat         one-cycle beat tick
//   beat_dir     registered copy of r_switch
module playback_sequencer #(
  parameter int BEAT_COUNT = 1000,
  parameter int NUM_SONGS  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_button,
  input  logic       next_button,
  input  logic       ff_switch,
  input  logic       r_switch,
  input  logic       new_frame,
  input  logic       song_done,
  output logic       play,
  output logic       song_reset,
  output logic [1:0] current_song,
  output logic       beat,
  output logic       beat_dir
);

  localparam int CW = $clog2(BEAT_COUNT);
  localparam logic [CW-1:0] TERM_NORM = CW'(BEAT_COUNT - 1);
  localparam logic [CW-1:0] TERM_FF   = CW'(BEAT_COUNT / 2 - 1);
  localparam logic [1:0]    LAST_SONG = 2'(NUM_SONGS - 1);

`ifdef AUTO_ADVANCE_EN
  localparam logic DONE_ADV = 1'b1;
`else
  localparam logic DONE_ADV = 1'b0;
`endif

  typedef enum logic [1:0] {PAUSED, PLAYING, RESTART} state_t;

  state_t        state;
  logic [CW-1:0] frame_cnt;
  logic          advance;
  logic          resume;
  logic [CW-1:0] term;

  // >= rather than == so switching to ff mid-beat (counter already past the
  // short terminal count) fires on the very next frame instead of wrapping.
  assign term = ff_switch ? TERM_FF : TERM_NORM;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PAUSED;
      play         <= 1'b0;
      song_reset   <= 1'b0;
      current_song <= 2'd0;
      beat         <= 1'b0;
      beat_dir     <= 1'b0;
      frame_cnt    <= '0;
      advance      <= 1'b0;
      resume       <= 1'b0;
    end else begin
      beat_dir   <= r_switch;
      play       <= (state == PLAYING);
      song_reset <= 1'b0;
      beat       <= 1'b0;
      case (state)
        PAUSED: begin
          if (next_button) begin
            state   <= RESTART;
            advance <= 1'b1;
            resume  <= 1'b0;
          end else if (play_button) begin
            state <= PLAYING;
          end
        end
        PLAYING: begin
          if (new_frame) begin
            if (frame_cnt >= term) begin
              frame_cnt <= '0;
              beat      <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
          if (next_button) begin
            state   <= RESTART;
            advance <= 1'b1;
            resume  <= 1'b0;
          end else if (song_done) begin
            state   <= RESTART;
            advance <= DONE_ADV;
            resume  <= DONE_ADV;
          end else if (play_button) begin
            state <= PAUSED;
          end
        end
        RESTART: begin
          song_reset <= 1'b1;
          frame_cnt  <= '0;
          if (advance)
            current_song <= (current_song == LAST_SONG) ? 2'd0 : current_song + 2'd1;
          state <= resume ? PLAYING : PAUSED;
        end
        default: state <= PAUSED;
      endcase
    end
  end

endmodule

// File: tb/tb_playback_sequencer.sv
module tb_playback_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       play_button = 1'b0, next_button = 1'b0, ff_switch = 1'b0, r_switch = 1'b0;
  logic       new_frame = 1'b0, song_done = 1'b0;
  logic       play, song_reset, beat, beat_dir;
  logic [1:0] current_song;

  logic       next2 = 1'b0;
  logic       play2, song_reset2, beat2, beat_dir2;
  logic [1:0] current_song2;

  int checks = 0;
  int failures = 0;
  int exp_song = 0;

  always #5 clk = ~clk;

  playback_sequencer #(.BEAT_COUNT(100), .NUM_SONGS(4)) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .ff_switch(ff_switch), .r_switch(r_switch), .new_frame(new_frame), .song_done(song_done),
    .play(play), .song_reset(song_reset), .current_song(current_song), .beat(beat),
    .beat_dir(beat_dir)
  );

  playback_sequencer #(.BEAT_COUNT(100), .NUM_SONGS(3)) dut3 (
    .clk(clk), .reset(reset), .play_button(1'b0), .next_button(next2),
    .ff_switch(1'b0), .r_switch(1'b0), .new_frame(1'b0), .song_done(1'b0),
    .play(play2), .song_reset(song_reset2), .current_song(current_song2), .beat(beat2),
    .beat_dir(beat_dir2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives n frames with an idle cycle between each; counts beats and flags
  // any beat that does not land right after a frame that is a multiple of period.
  task automatic run_frames(input int n, input int period, output int nbeats, output int bad);
    nbeats = 0;
    bad = 0;
    for (int i = 1; i <= n; i++) begin
      new_frame = 1'b1;
      step();
      new_frame = 1'b0;
      if (beat) begin
        nbeats++;
        if (i % period != 0) bad++;
      end else if (i % period == 0) bad++;
      step();
      if (beat) bad++;
    end
  endtask

  task automatic start_play();
    play_button = 1'b1;
    step();
    play_button = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (play !== 1'b0) begin failures++; $display("FAIL reset_play got=%b exp=0", play); end
    checks++; if (current_song !== 2'd0) begin failures++; $display("FAIL reset_song got=%0d exp=0", current_song); end
    checks++; if (beat !== 1'b0) begin failures++; $display("FAIL reset_beat got=%b exp=0", beat); end
    checks++; if (song_reset !== 1'b0) begin failures++; $display("FAIL reset_song_reset got=%b exp=0", song_reset); end
    checks++; if (beat_dir !== 1'b0) begin failures++; $display("FAIL reset_beat_dir got=%b exp=0", beat_dir); end
    reset = 1'b1;
    step();
  endtask

  task automatic test_play_beats();
    int nb, bad;
    play_button = 1'b1;
    step();
    play_button = 1'b0;
    checks++; if (play !== 1'b0) begin failures++; $display("FAIL play_lat1 got=%b exp=0", play); end
    step();
    checks++; if (play !== 1'b1) begin failures++; $display("FAIL play_lat2 got=%b exp=1", play); end
    run_frames(300, 100, nb, bad);
    checks++; if (nb !== 3) begin failures++; $display("FAIL beats_normal got=%0d exp=3", nb); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL beats_normal_place got=%0d exp=0", bad); end
  endtask

  task automatic test_ff();
    int nb, bad;
    ff_switch = 1'b1;
    run_frames(100, 50, nb, bad);
    checks++; if (nb !== 2) begin failures++; $display("FAIL beats_ff got=%0d exp=2", nb); end
    checks++; if (bad !== 0) begin failures++; $display("FAIL beats_ff_place got=%0d exp=0", bad); end
    ff_switch = 1'b0;
    run_frames(70, 100, nb, bad);
    checks++; if (nb !== 0) begin failures++; $display("FAIL beats_pre70 got=%0d exp=0", nb); end
    ff_switch = 1'b1;
    new_frame = 1'b1;
    step();
    new_frame = 1'b0;
    checks++; if (beat !== 1'b1) begin failures++; $display("FAIL beat_ff_switch71 got=%b exp=1", beat); end
    step();
    run_frames(50, 50, nb, bad);
    checks++; if (nb !== 1 || bad !== 0) begin failures++; $display("FAIL beats_after_switch got=%0d/%0d exp=1/0", nb, bad); end
    ff_switch = 1'b0;
  endtask

  task automatic test_reverse();
    int nb, bad;
    r_switch = 1'b1;
    step();
    checks++; if (beat_dir !== 1'b1) begin failures++; $display("FAIL beat_dir got=%b exp=1", beat_dir); end
    run_frames(100, 100, nb, bad);
    checks++; if (nb !== 1 || bad !== 0) begin failures++; $display("FAIL beats_reverse got=%0d/%0d exp=1/0", nb, bad); end
    r_switch = 1'b0;
    step();
  endtask

  task automatic test_song_done();
    logic exp_play;
`ifdef AUTO_ADVANCE_EN
    exp_song = 1;
    exp_play = 1'b1;
`else
    exp_song = 0;
    exp_play = 1'b0;
`endif
    song_done = 1'b1;
    step();
    song_done = 1'b0;
    step();
    checks++; if (song_reset !== 1'b1) begin failures++; $display("FAIL done_song_reset got=%b exp=1", song_reset); end
    checks++; if (current_song !== 2'(exp_song)) begin failures++; $display("FAIL done_song got=%0d exp=%0d", current_song, exp_song); end
    step();
    checks++; if (play !== exp_play) begin failures++; $display("FAIL done_play got=%b exp=%b", play, exp_play); end
    checks++; if (song_reset !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", song_reset); end
  endtask

  task automatic test_back_to_back();
    if (play !== 1'b1) start_play();
    play_button = 1'b1;
    next_button = 1'b1;
    step();
    play_button = 1'b0;
    next_button = 1'b0;
    step();
    exp_song = (exp_song + 1) % 4;
    checks++; if (song_reset !== 1'b1) begin failures++; $display("FAIL simul_song_reset got=%b exp=1", song_reset); end
    checks++; if (current_song !== 2'(exp_song)) begin failures++; $display("FAIL simul_song got=%0d exp=%0d", current_song, exp_song); end
    repeat (2) step();
    checks++; if (play !== 1'b0) begin failures++; $display("FAIL simul_paused got=%b exp=0", play); end
  endtask

  task automatic test_async_reset();
    start_play();
    r_switch = 1'b1;
    step();
    reset = 1'b0;
    #2;
    checks++; if (play !== 1'b0) begin failures++; $display("FAIL async_play got=%b exp=0", play); end
    checks++; if (beat_dir !== 1'b0) begin failures++; $display("FAIL async_beat_dir got=%b exp=0", beat_dir); end
    checks++; if (current_song !== 2'd0) begin failures++; $display("FAIL async_song got=%0d exp=0", current_song); end
    r_switch = 1'b0;
    step();
    reset = 1'b1;
    step();
    step();
    checks++; if (play !== 1'b0) begin failures++; $display("FAIL post_reset_play got=%b exp=0", play); end
  endtask

  task automatic test_next_paused();
    for (int k = 1; k <= 4; k++) begin
      next_button = 1'b1;
      step();
      next_button = 1'b0;
      new_frame = 1'b1;
      step();
      new_frame = 1'b0;
      checks++; if (song_reset !== 1'b1) begin failures++; $display("FAIL next_song_reset%0d got=%b exp=1", k, song_reset); end
      checks++; if (current_song !== 2'(k % 4)) begin failures++; $display("FAIL next_song%0d got=%0d exp=%0d", k, current_song, k % 4); end
      checks++; if (beat !== 1'b0 || play !== 1'b0) begin failures++; $display("FAIL next_beat_play%0d got=%b%b exp=00", k, beat, play); end
      step();
      checks++; if (song_reset !== 1'b0) begin failures++; $display("FAIL next_pulse%0d got=%b exp=0", k, song_reset); end
    end
    song_done = 1'b1;
    step();
    song_done = 1'b0;
    step();
    checks++; if (song_reset !== 1'b0 || play !== 1'b0) begin failures++; $display("FAIL done_paused got=%b%b exp=00", song_reset, play); end
  endtask

  task automatic test_wrap3();
    for (int k = 1; k <= 3; k++) begin
      next2 = 1'b1;
      step();
      next2 = 1'b0;
      step();
      checks++; if (current_song2 !== 2'(k % 3)) begin failures++; $display("FAIL wrap3_song%0d got=%0d exp=%0d", k, current_song2, k % 3); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_play_beats();
    test_ff();
    test_reverse();
    test_song_done();
    test_back_to_back();
    test_async_reset();
    test_next_paused();
    test_wrap3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
